// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DEF_NUM_W = 6;
  localparam int DEF_DEN_W = 3;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring shift-subtract step: shift in a dividend bit, subtract divisor if it fits.
module div_restoring_step #(
  parameter int DEN_W = 3
) (
  input  logic [DEN_W-1:0] r,
  input  logic             n_bit,
  input  logic [DEN_W-1:0] denom,
  output logic [DEN_W-1:0] r_next,
  output logic             q_bit
);

  logic [DEN_W:0] r_ext;

  // The difference is always < denom when taken, so DEN_W-bit modular subtraction is exact.
  always_comb begin
    r_ext  = {r, n_bit};
    q_bit  = (r_ext >= {1'b0, denom});
    r_next = q_bit ? (r_ext[DEN_W-1:0] - denom) : r_ext[DEN_W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for an operation, in_ready=1
//   BUSY  | one shift-subtract step per clock
//   DONE  | result presented, out_valid=1 until out_ready
module seq_divider
  import divider_pkg::*;
#(
  parameter int NUM_W = DEF_NUM_W,
  parameter int DEN_W = DEF_DEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] numer,
  input  logic [DEN_W-1:0] denom,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W-1:0] remain,
  output logic             div_by_zero
);

  localparam int CNT_W = clog2(NUM_W);

  if (DEN_W > NUM_W || NUM_W < 2 || DEN_W < 1) begin : g_bad_params
    $error("seq_divider: need NUM_W >= 2, DEN_W >= 1 and DEN_W <= NUM_W");
  end

  div_state_t       state_q, state_d;
  // Dividend shifts out of the MSB while quotient bits shift into the freed LSBs.
  logic [NUM_W-1:0] nq_q;
  logic [DEN_W-1:0] r_q;
  logic [DEN_W-1:0] d_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DEN_W-1:0] r_next;
  logic             q_bit;
  logic             accept;
  logic             last_step;

  div_restoring_step #(.DEN_W(DEN_W)) u_step (
    .r      (r_q),
    .n_bit  (nq_q[NUM_W-1]),
    .denom  (d_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == BUSY) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (denom == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nq_q        <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remain      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        nq_q  <= numer;
        d_q   <= denom;
        r_q   <= '0;
        cnt_q <= CNT_W'(NUM_W - 1);
        if (denom == '0) begin
          quotient    <= '1;
          remain      <= numer[DEN_W-1:0];
          div_by_zero <= 1'b1;
        end
      end else if (state_q == BUSY) begin
        nq_q  <= {nq_q[NUM_W-2:0], q_bit};
        r_q   <= r_next;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quotient    <= {nq_q[NUM_W-2:0], q_bit};
          remain      <= r_next;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed self-checking bench for seq_divider against an arithmetic model.
module tb_seq_divider;

  localparam int NUM_W = 6;
  localparam int DEN_W = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NUM_W-1:0] numer;
  logic [DEN_W-1:0] denom;
  logic             out_valid;
  logic             out_ready;
  logic [NUM_W-1:0] quotient;
  logic [DEN_W-1:0] remain;
  logic             div_by_zero;

  int n_checks;
  int n_fail;
  int cyc;
  int prev_acc;
  bit have_prev;

  seq_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .numer       (numer),
    .denom       (denom),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remain      (remain),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait for out_valid; checks latency and the result.
  task automatic run_op(input int n, input int d, input bit tput);
    int waitc;
    int lat;
    int eq, er, ez;
    waitc = 0;
    while (!in_ready && waitc < 20) begin tick(); waitc++; end
    check("in_ready_before_op", in_ready, 1);
    numer    = n[NUM_W-1:0];
    denom    = d[DEN_W-1:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (tput && have_prev) check("throughput", cyc - prev_acc, NUM_W + 2);
    prev_acc  = cyc;
    have_prev = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("in_ready_busy", in_ready, 0);
      tick();
      lat++;
    end
    if (d == 0) begin
      eq = (1 << NUM_W) - 1;
      er = n % (1 << DEN_W);
      ez = 1;
    end else begin
      eq = n / d;
      er = n % d;
      ez = 0;
    end
    check("latency", lat, (d == 0) ? 0 : NUM_W);
    check("quotient", quotient, eq);
    check("remain", remain, er);
    check("div_by_zero", div_by_zero, ez);
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    tick();
    check("out_valid_after_accept", out_valid, 0);
    check("in_ready_after_accept", in_ready, 1);
  endtask

  initial begin
    int k;
    int n, d;
    n_checks  = 0;
    n_fail    = 0;
    have_prev = 1'b0;
    prev_acc  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    numer     = '0;
    denom     = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remain", remain, 0);
    check("reset_div_by_zero", div_by_zero, 0);

    // Directed cases, including divide-by-zero and edge values.
    run_op(23, 5, 0); accept_result();
    run_op(42, 0, 0); accept_result();
    run_op(3, 7, 0);  accept_result();
    run_op(63, 1, 0); accept_result();
    run_op(0, 4, 0);  accept_result();
    run_op(0, 0, 0);  accept_result();

    // Back-to-back exhaustive sweep at full out_ready.
    have_prev = 1'b0;
    for (int dd = 1; dd < 8; dd++) begin
      for (int nn = 0; nn < 64; nn++) begin
        run_op(nn, dd, 1);
        accept_result();
      end
    end

    // Backpressure: hold DONE for 10 cycles while poking in_valid.
    out_ready = 1'b0;
    run_op(45, 6, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      numer    = 6'($urandom_range(0, 63));
      denom    = 3'($urandom_range(0, 7));
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_quotient", quotient, 7);
      check("bp_remain", remain, 3);
    end
    in_valid = 1'b0;
    accept_result();

    // Reset pulse during the third BUSY cycle aborts the operation.
    numer    = 6'd61;
    denom    = 3'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remain", remain, 0);
    check("abort_div_by_zero", div_by_zero, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_valid", out_valid, 0);
    end
    run_op(50, 6, 0);
    accept_result();

    // Random operations with random consumer stall.
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 63);
      d = $urandom_range(0, 7);
      k = $urandom_range(0, 3);
      out_ready = 1'b0;
      run_op(n, d, 0);
      for (int j = 0; j < k; j++) begin
        tick();
        check("rnd_hold_valid", out_valid, 1);
        check("rnd_hold_quotient", quotient, (d == 0) ? 63 : n / d);
      end
      accept_result();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
